// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, RGB565 colours and coordinate types for the video timing path.
package vga_timing_pkg;

    localparam int COORD_W = 12;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [15:0]        rgb565_t;

    // Stage-0 timing decodes, always active-high inside the pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } tsig_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source request/return and transmitter-facing video bus of the timing generator.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t  pic_x;
    coord_t  pic_y;
    rgb565_t pic_data;
    rgb565_t rgb_o;
    logic    hsync_o;
    logic    vsync_o;
    logic    de_o;
    logic    frame_start_o;

    modport master (
        output pic_x, pic_y, rgb_o, hsync_o, vsync_o, de_o, frame_start_o,
        input  pic_data
    );

    modport slave (
        input  pic_x, pic_y, rgb_o, hsync_o, vsync_o, de_o, frame_start_o,
        output pic_data
    );

endinterface

// File: rtl/vga_timing_gen_sig_delay.sv
// Enable-gated shift register of configurable width and depth.
// Latency: DEPTH advancing cycles.
// Backpressure: none; en low freezes every stage.
module sig_delay #(
    parameter int W     = 4,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: drives pixel-source coordinates and realigns sync/de with the returned pixel.
// Latency: PIC_LATENCY+1 cycles from counter state to hsync/vsync/de/rgb outputs.
// Backpressure: none; en low holds all state and forces frame_start_o low.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   PIC_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    vga_timing_gen_if.master  vif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 4095 || V_TOTAL > 4095 || PIC_LATENCY < 1 || PIC_LATENCY > 4) begin : g_param_err
        $fatal(1, "vga_timing_gen: totals must fit 12 bits and PIC_LATENCY must be 1..4");
    end

    coord_t      h_cnt;
    coord_t      v_cnt;
    logic [31:0] h_ext;
    logic [31:0] v_ext;
    logic        h_last;
    logic        v_last;
    logic        h_act;
    logic        v_act;
    tsig_t       tsig0;
    tsig_t       tsig_d;

    // Totals are 32-bit sums, so compare against zero-extended counters.
    assign h_ext  = 32'(h_cnt);
    assign v_ext  = 32'(v_cnt);
    assign h_last = (h_ext == 32'(H_TOTAL - 1));
    assign v_last = (v_ext == 32'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    assign h_act    = (h_ext < 32'(H_ACTIVE));
    assign v_act    = (v_ext < 32'(V_ACTIVE));
    assign tsig0.de = h_act & v_act;
    assign tsig0.hs = (h_ext >= 32'(HS_START)) && (h_ext < 32'(HS_END));
    // v_cnt only moves on the line wrap, so vsync edges land on h_cnt = 0.
    assign tsig0.vs = (v_ext >= 32'(VS_START)) && (v_ext < 32'(VS_END));
    assign tsig0.fs = (h_cnt == '0) && (v_cnt == '0);

    assign vif.pic_x = h_act ? h_cnt : '0;
    assign vif.pic_y = v_act ? v_cnt : '0;

    sig_delay #(
        .W     ($bits(tsig_t)),
        .DEPTH (PIC_LATENCY)
    ) u_sig_delay (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (tsig0),
        .q   (tsig_d)
    );

    // tsig_d now lines up with pic_data returned for the same coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            vif.hsync_o       <= ~SYNC_POL;
            vif.vsync_o       <= ~SYNC_POL;
            vif.de_o          <= 1'b0;
            vif.rgb_o         <= RGB565_BLACK;
            vif.frame_start_o <= 1'b0;
        end else if (en) begin
            vif.hsync_o       <= tsig_d.hs ? SYNC_POL : ~SYNC_POL;
            vif.vsync_o       <= tsig_d.vs ? SYNC_POL : ~SYNC_POL;
            vif.de_o          <= tsig_d.de;
            vif.rgb_o         <= tsig_d.de ? vif.pic_data : RGB565_BLACK;
            vif.frame_start_o <= tsig_d.fs;
        end else begin
            vif.frame_start_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized en/rst stimulus on a small-raster and a default-raster instance, checked each cycle against a raster-position model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int A_HA = 20, A_HF = 4, A_HS = 6, A_HB = 5;
    localparam int A_VA = 12, A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_LAT = 3;
    localparam int B_LAT = 1;

    typedef struct {
        int   ha, hf, hsw, hb, va, vf, vsw, vb, lat;
        logic pol;
    } tim_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] rgb;
        logic [11:0] px;
        logic [11:0] py;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic en;
    int   n_cmp = 0;
    int   n_err = 0;
    int   steps_a = 0;
    int   steps_b = 0;
    tim_t ta;
    tim_t tb_t;

    always #5 clk = ~clk;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();

    vga_timing_gen #(
        .H_ACTIVE (A_HA), .H_FP (A_HF), .H_SYNC (A_HS), .H_BP (A_HB),
        .V_ACTIVE (A_VA), .V_FP (A_VF), .V_SYNC (A_VS), .V_BP (A_VB),
        .SYNC_POL (1'b0), .PIC_LATENCY (A_LAT)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .en  (en),
        .vif (if_a.master)
    );

    vga_timing_gen #(
        .PIC_LATENCY (B_LAT)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .en  (en),
        .vif (if_b.master)
    );

    // Pixel sources echo {x[7:0], y[7:0]} after their latency, sharing the clock enable.
    logic [15:0] pipe_a [A_LAT];
    logic [15:0] pipe_b [B_LAT];

    always @(posedge clk) begin
        if (en) begin
            pipe_a[0] <= {if_a.pic_x[7:0], if_a.pic_y[7:0]};
            for (int i = 1; i < A_LAT; i++) pipe_a[i] <= pipe_a[i-1];
            pipe_b[0] <= {if_b.pic_x[7:0], if_b.pic_y[7:0]};
            for (int i = 1; i < B_LAT; i++) pipe_b[i] <= pipe_b[i-1];
        end
    end

    assign if_a.pic_data = pipe_a[A_LAT-1];
    assign if_b.pic_data = pipe_b[B_LAT-1];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs from the number of enabled cycles since reset released:
    // coordinates show the current raster position, outputs show the one lat+1 steps back.
    function automatic exp_t ref_model(input int steps, input bit en_last, input tim_t t);
        int   ht = t.ha + t.hf + t.hsw + t.hb;
        int   vt = t.va + t.vf + t.vsw + t.vb;
        int   m  = steps - (t.lat + 1);
        int   h;
        int   v;
        exp_t e;
        e    = '0;
        e.hs = ~t.pol;
        e.vs = ~t.pol;
        h    = steps % ht;
        v    = (steps / ht) % vt;
        e.px = (h < t.ha) ? 12'(h) : 12'd0;
        e.py = (v < t.va) ? 12'(v) : 12'd0;
        if (m >= 0) begin
            h    = m % ht;
            v    = (m / ht) % vt;
            e.de = (h < t.ha) && (v < t.va);
            if (h >= t.ha + t.hf && h < t.ha + t.hf + t.hsw) e.hs = t.pol;
            if (v >= t.va + t.vf && v < t.va + t.vf + t.vsw) e.vs = t.pol;
            e.fs = en_last && (h == 0) && (v == 0);
            if (e.de) e.rgb = {h[7:0], v[7:0]};
        end
        return e;
    endfunction

    task automatic check_dut(input string nm, input int steps, input bit en_last, input tim_t t,
                             input logic hs, input logic vs, input logic de, input logic fs,
                             input logic [15:0] rgb, input logic [11:0] px, input logic [11:0] py);
        exp_t e;
        e = ref_model(steps, en_last, t);
        chk_eq({nm, ".hsync"}, 32'(hs),  32'(e.hs));
        chk_eq({nm, ".vsync"}, 32'(vs),  32'(e.vs));
        chk_eq({nm, ".de"},    32'(de),  32'(e.de));
        chk_eq({nm, ".fs"},    32'(fs),  32'(e.fs));
        chk_eq({nm, ".rgb"},   32'(rgb), 32'(e.rgb));
        chk_eq({nm, ".pic_x"}, 32'(px),  32'(e.px));
        chk_eq({nm, ".pic_y"}, 32'(py),  32'(e.py));
    endtask

    initial begin
        ta   = '{ha: A_HA, hf: A_HF, hsw: A_HS, hb: A_HB, va: A_VA, vf: A_VF, vsw: A_VS, vb: A_VB,
                 lat: A_LAT, pol: 1'b0};
        tb_t = '{ha: VGA_H_ACTIVE, hf: VGA_H_FP, hsw: VGA_H_SYNC, hb: VGA_H_BP,
                 va: VGA_V_ACTIVE, vf: VGA_V_FP, vsw: VGA_V_SYNC, vb: VGA_V_BP,
                 lat: B_LAT, pol: 1'b0};
        rst_a = 1'b1;
        rst_b = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            // Inputs still hold the values sampled at the edge just passed.
            if (rst_a) steps_a = 0; else if (en) steps_a++;
            if (rst_b) steps_b = 0; else if (en) steps_b++;
            check_dut("a", steps_a, en, ta, if_a.hsync_o, if_a.vsync_o, if_a.de_o,
                      if_a.frame_start_o, if_a.rgb_o, if_a.pic_x, if_a.pic_y);
            check_dut("b", steps_b, en, tb_t, if_b.hsync_o, if_b.vsync_o, if_b.de_o,
                      if_b.frame_start_o, if_b.rgb_o, if_b.pic_x, if_b.pic_y);

            rst_b = (i < 2);
            rst_a = (i < 2) || (i == 1000) || (i >= 3000 && $urandom_range(0, 249) == 0);
            if (i < 1500)      en = 1'b1;
            else if (i < 3000) en = (i % 2 == 0);
            else               en = ($urandom_range(0, 3) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
